// File: rtl/aes_seq_pkg.sv
// ---------------------------------------------------------------------------
// aes_seq_pkg
// Shared definitions for the AES block sequencer: block width, mode
// encodings and the sequencer FSM state type.
// ---------------------------------------------------------------------------
package aes_seq_pkg;

   localparam int AES_BLK_W = 128;

   localparam logic MODE_ECB = 1'b0;
   localparam logic MODE_CTR = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// ---------------------------------------------------------------------------
// aes_blk_fifo
// Synchronous block FIFO with registered full/empty flags. The head entry is
// read combinationally from storage, so a block is only visible one cycle
// after it is pushed (no write-to-read pass-through).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers/flags only)
//   push        write wr_data when not full (ignored while full)
//   pop         retire head entry when not empty
//   wr_data     block to store
//   full        registered full flag
//   empty       registered empty flag
//   head        oldest stored block
// ---------------------------------------------------------------------------
module aes_blk_fifo
   import aes_seq_pkg::*;
#(
   parameter int WIDTH = AES_BLK_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      count_nxt;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the registered flag, so a pop in the same cycle
   // does not open a slot for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + (AW+1)'(1);
         2'b01:   count_nxt = count - (AW+1)'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == (AW+1)'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

   // Storage carries data only; it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/aes_block_sequencer.sv
// ---------------------------------------------------------------------------
// aes_block_sequencer
// Streaming front-end for the AES_top core. Input blocks are queued in a
// FIFO, issued one at a time over the core's en/valid handshake and the
// results presented on a valid/ready output. ECB passes the core result
// straight through; CTR encrypts {iv[127:CTR_W], ctr} and XORs the keystream
// with the queued block.
//
// Ports:
//   AES_clk, AES_rst_n         clock, asynchronous active-low reset
//   cfg_load/mode/key/iv       configuration, accepted only when idle and
//                              the output register is empty
//   in_valid/in_ready/in_data  input block stream
//   out_valid/out_ready/out_data  result stream (held until accepted)
//   core_en/core_data_in/core_key    drive AES_top
//   core_data_out/core_data_out_valid  AES_top result
//   busy         FSM active or blocks queued
//   err_timeout  sticky: core failed to answer within TIMEOUT cycles
//   blk_count    completed blocks, wraps
// ---------------------------------------------------------------------------
module aes_block_sequencer
   import aes_seq_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CTR_W      = 32,
   parameter int GAP_CYCLES = 1,
   parameter int TIMEOUT    = 64,
   parameter int CNT_W      = 16
) (
   input  logic                 AES_clk,
   input  logic                 AES_rst_n,
   input  logic                 cfg_load,
   input  logic                 cfg_mode,
   input  logic [AES_BLK_W-1:0] cfg_key,
   input  logic [AES_BLK_W-1:0] cfg_iv,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 core_en,
   output logic [AES_BLK_W-1:0] core_data_in,
   output logic [AES_BLK_W-1:0] core_key,
   input  logic [AES_BLK_W-1:0] core_data_out,
   input  logic                 core_data_out_valid,
   output logic                 busy,
   output logic                 err_timeout,
   output logic [CNT_W-1:0]     blk_count
);

   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   seq_state_t           state;
   logic                 mode;
   logic [AES_BLK_W-1:0] iv;
   logic [CTR_W-1:0]     ctr;
   logic [TMO_W-1:0]     tmo_cnt;
   logic [GAP_W-1:0]     gap_cnt;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [AES_BLK_W-1:0] fifo_head;

   logic                 cfg_ok;
   logic                 out_take;
   logic                 start;
   logic                 done;
   logic                 tmo_hit;

   aes_blk_fifo #(
      .WIDTH (AES_BLK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (AES_clk),
      .rst_n   (AES_rst_n),
      .push    (in_valid),
      .pop     (fifo_pop),
      .wr_data (in_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   assign in_ready = !fifo_full;
   assign busy     = (state != IDLE) || !fifo_empty;
   assign cfg_ok   = cfg_load && !busy && !out_valid;
   assign out_take = out_valid && out_ready;

   // Only start a block when its result will have somewhere to go.
   assign start   = (state == IDLE) && !fifo_empty && (!out_valid || out_ready);
   assign done    = (state == ISSUE) && core_data_out_valid;
   assign tmo_hit = (state == ISSUE) && !core_data_out_valid &&
                    (tmo_cnt == TMO_W'(TIMEOUT - 1));

   // A timed-out block is dropped, so the head leaves the FIFO either way.
   assign fifo_pop = done || tmo_hit;

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         state        <= IDLE;
         mode         <= MODE_ECB;
         iv           <= '0;
         core_key     <= '0;
         ctr          <= '0;
         core_en      <= 1'b0;
         core_data_in <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         blk_count    <= '0;
         err_timeout  <= 1'b0;
         tmo_cnt      <= '0;
         gap_cnt      <= '0;
      end else begin
         if (out_take) out_valid <= 1'b0;

         // cfg_ok implies IDLE, so it never competes with the FSM updates.
         if (cfg_ok) begin
            mode        <= cfg_mode;
            core_key    <= cfg_key;
            iv          <= cfg_iv;
            ctr         <= cfg_iv[CTR_W-1:0];
            err_timeout <= 1'b0;
            blk_count   <= '0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= ISSUE;
                  core_en <= 1'b1;
                  tmo_cnt <= '0;
                  // Captured once so the core sees a constant operand.
                  core_data_in <= (mode == MODE_CTR) ?
                                  {iv[AES_BLK_W-1:CTR_W], ctr} : fifo_head;
               end
            end
            ISSUE: begin
               if (core_data_out_valid) begin
                  state     <= GAP;
                  core_en   <= 1'b0;
                  gap_cnt   <= '0;
                  out_valid <= 1'b1;
                  out_data  <= (mode == MODE_CTR) ?
                               (core_data_out ^ fifo_head) : core_data_out;
                  blk_count <= blk_count + CNT_W'(1);
                  if (mode == MODE_CTR) ctr <= ctr + CTR_W'(1);
               end else if (tmo_hit) begin
                  state       <= GAP;
                  core_en     <= 1'b0;
                  gap_cnt     <= '0;
                  err_timeout <= 1'b1;
                  // Keep the keystream aligned with block order.
                  if (mode == MODE_CTR) ctr <= ctr + CTR_W'(1);
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state <= IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: begin
               state   <= IDLE;
               core_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_block_sequencer
// Directed bench for aes_block_sequencer with a behavioural AES_top stand-in:
// known FIPS-197 / SP800-38A operands return their published results, any
// other operand returns a simple keyed permutation.
// ---------------------------------------------------------------------------
module tb_aes_block_sequencer;

   localparam int FD   = 4;
   localparam int CW   = 32;
   localparam int GAPC = 1;
   localparam int TMO  = 16;
   localparam int NW   = 16;
   localparam int MDLY = 3;          // core model: valid MDLY edges after en seen
   localparam int HI   = MDLY + 1;   // cycles core_en is high per block

   localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_NIST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] CB1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
   localparam logic [127:0] CB2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
   localparam logic [127:0] CB3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
   localparam logic [127:0] KS0 = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
   localparam logic [127:0] KS1 = 128'h362b7c3c6773516318a077d7fc5073ae;
   localparam logic [127:0] KS2 = 128'h6a2cc3787889374fbeb4c81b17ba6c44;
   localparam logic [127:0] KS3 = 128'he89c399ff0f198c6d40a31db156cabfe;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cfg_load, cfg_mode;
   logic [127:0] cfg_key, cfg_iv;
   logic         in_valid, in_ready;
   logic [127:0] in_data;
   logic         out_valid, out_ready;
   logic [127:0] out_data;
   logic         core_en;
   logic [127:0] core_data_in, core_key, core_data_out;
   logic         core_data_out_valid;
   logic         busy, err_timeout;
   logic [NW-1:0] blk_count;

   logic         m_valid, inj_valid, hang;
   int           mcnt;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   aes_block_sequencer #(
      .FIFO_DEPTH (FD), .CTR_W (CW), .GAP_CYCLES (GAPC), .TIMEOUT (TMO), .CNT_W (NW)
   ) dut (
      .AES_clk (clk), .AES_rst_n (rst_n),
      .cfg_load (cfg_load), .cfg_mode (cfg_mode), .cfg_key (cfg_key), .cfg_iv (cfg_iv),
      .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .core_en (core_en), .core_data_in (core_data_in), .core_key (core_key),
      .core_data_out (core_data_out), .core_data_out_valid (core_data_out_valid),
      .busy (busy), .err_timeout (err_timeout), .blk_count (blk_count)
   );

   function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] d);
      if (k == K_FIPS && d == P_FIPS) return C_FIPS;
      if (k == K_NIST && d == CB0) return KS0;
      if (k == K_NIST && d == CB1) return KS1;
      if (k == K_NIST && d == CB2) return KS2;
      if (k == K_NIST && d == CB3) return KS3;
      return {d[63:0], d[127:64]} ^ k ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
   endfunction

   // Core stand-in: answers MDLY edges after it first sees core_en.
   always @(posedge clk) begin
      if (core_en && !hang) begin
         if (mcnt == MDLY - 1) begin
            m_valid       <= 1'b1;
            core_data_out <= enc(core_key, core_data_in);
            mcnt          <= 0;
         end else begin
            m_valid <= 1'b0;
            mcnt    <= mcnt + 1;
         end
      end else begin
         m_valid <= 1'b0;
         mcnt    <= 0;
      end
   end

   assign core_data_out_valid = m_valid | inj_valid;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, 128'(obs), 128'(exp));
   endtask

   task automatic wait_en(input string tag);
      int n = 0;
      while (core_en !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk1({tag, "_en_seen"}, core_en, 1'b1);
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      while (out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk1({tag, "_out_seen"}, out_valid, 1'b1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || out_valid) && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) chk1("idle_wait", busy, 1'b0);
   endtask

   task automatic push(input logic [127:0] d);
      int n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk1("push_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_cfg(input logic m, input logic [127:0] k, input logic [127:0] v);
      wait_idle();
      cfg_mode = m;
      cfg_key  = k;
      cfg_iv   = v;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pt [4];
      logic [127:0] ct [4];
      logic [127:0] cb [4];
      logic [127:0] bp [5];
      logic [127:0] p2, iv_w, cb_w1, k3, k4, k5, held;
      int hi, lo;
      logic mv_prev;

      pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
      ct[0] = 128'h874d6191b620e3261bef6864990db6ce;
      ct[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
      ct[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
      ct[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;
      cb[0] = CB0; cb[1] = CB1; cb[2] = CB2; cb[3] = CB3;

      rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = 1'b0; cfg_key = '0; cfg_iv = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; hang = 1'b0; inj_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_core_en", core_en, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err_timeout, 1'b0);
      chk("rst_blk_count", 128'(blk_count), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_core_key", core_key, 128'd0);
      chk("rst_core_data_in", core_data_in, 128'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: ECB FIPS-197, latency and block spacing
      do_cfg(1'b0, K_FIPS, 128'd0);
      out_ready = 1'b1;
      p2 = 128'h0123456789abcdeffedcba9876543210;
      push(P_FIPS);
      chk1("t1_en_after_push", core_en, 1'b0);
      in_valid = 1'b1; in_data = p2;
      @(negedge clk);
      in_valid = 1'b0;
      chk1("t1_en_next_edge", core_en, 1'b1);
      chk("t1_core_data_in", core_data_in, P_FIPS);
      chk("t1_core_key", core_key, K_FIPS);
      hi = 1; mv_prev = 1'b0;
      while (core_en && hi < 100) begin
         mv_prev = m_valid;
         @(negedge clk);
         if (core_en) hi++;
      end
      chk("t1_en_high_cycles", 128'(hi), 128'(HI));
      chk1("t1_valid_before_drop", mv_prev, 1'b1);
      chk1("t1_out_valid", out_valid, 1'b1);
      chk("t1_out_data", out_data, C_FIPS);
      chk("t1_blk_count", 128'(blk_count), 128'd1);
      lo = 1;
      while (!core_en && lo < 100) begin
         @(negedge clk);
         if (!core_en) lo++;
      end
      chk1("t1_gap_min", lo >= GAPC, 1'b1);
      chk("t1_period", 128'(hi + lo), 128'(HI + GAPC + 1));
      chk("t1_core_data_in2", core_data_in, p2);
      wait_out("t1b");
      chk("t1_out_data2", out_data, enc(K_FIPS, p2));
      chk("t1_blk_count2", 128'(blk_count), 128'd2);
      @(negedge clk);

      // 2: CTR SP800-38A
      do_cfg(1'b1, K_NIST, CB0);
      chk("t2_cfg_clears_count", 128'(blk_count), 128'd0);
      for (int i = 0; i < 4; i++) push(pt[i]);
      for (int i = 0; i < 4; i++) begin
         wait_en("t2");
         chk($sformatf("t2_ctr_blk%0d", i), core_data_in, cb[i]);
         wait_out("t2");
         chk($sformatf("t2_ct%0d", i), out_data, ct[i]);
         @(negedge clk);
      end
      chk("t2_blk_count", 128'(blk_count), 128'd4);

      // 3: CTR counter wrap
      k3    = 128'h11112222333344445555666677778888;
      iv_w  = 128'h0123456789abcdef01234567ffffffff;
      cb_w1 = {iv_w[127:32], 32'h00000000};
      do_cfg(1'b1, k3, iv_w);
      push(128'haaaa);
      push(128'hbbbb);
      wait_en("t3a");
      chk("t3_ctr_blk0", core_data_in, iv_w);
      wait_out("t3a");
      chk("t3_out0", out_data, enc(k3, iv_w) ^ 128'haaaa);
      @(negedge clk);
      wait_en("t3b");
      chk("t3_ctr_wrap", core_data_in, cb_w1);
      wait_out("t3b");
      chk("t3_out1", out_data, enc(k3, cb_w1) ^ 128'hbbbb);
      @(negedge clk);

      // 4: Backpressure
      k4 = 128'hdeadbeef_00000000_cafef00d_12345678;
      do_cfg(1'b0, k4, 128'd0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) bp[i] = {4{32'h10000000 + 32'(i)}};
      for (int i = 0; i < 5; i++) push(bp[i]);
      repeat (2) @(negedge clk);
      chk1("t4_out_valid", out_valid, 1'b1);
      chk("t4_out_data", out_data, enc(k4, bp[0]));
      chk1("t4_in_ready_full", in_ready, 1'b0);
      chk1("t4_busy", busy, 1'b1);
      held = out_data;
      repeat (10) @(negedge clk);
      chk("t4_out_stable", out_data, held);
      chk1("t4_out_valid_held", out_valid, 1'b1);
      chk1("t4_still_full", in_ready, 1'b0);
      chk1("t4_core_idle", core_en, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_out("t4");
         chk($sformatf("t4_order%0d", i), out_data, enc(k4, bp[i]));
         @(negedge clk);
      end
      chk("t4_blk_count", 128'(blk_count), 128'd5);

      // 5: Timeout
      k5 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      do_cfg(1'b0, k5, 128'd0);
      hang = 1'b1;
      push(128'h5555);
      wait_en("t5");
      repeat (TMO - 1) @(negedge clk);
      chk1("t5_err_before", err_timeout, 1'b0);
      chk1("t5_en_before", core_en, 1'b1);
      @(negedge clk);
      chk1("t5_err_set", err_timeout, 1'b1);
      chk1("t5_en_dropped", core_en, 1'b0);
      chk1("t5_no_out", out_valid, 1'b0);
      chk("t5_count_same", 128'(blk_count), 128'd0);
      hang = 1'b0;
      push(128'h6666);
      wait_en("t5b");
      wait_out("t5b");
      chk("t5_next_block", out_data, enc(k5, 128'h6666));
      chk("t5_count_next", 128'(blk_count), 128'd1);
      chk1("t5_err_sticky", err_timeout, 1'b1);
      @(negedge clk);
      do_cfg(1'b0, k5, 128'd0);
      chk1("t5_cfg_clears_err", err_timeout, 1'b0);
      chk("t5_cfg_clears_count", 128'(blk_count), 128'd0);

      // 6: Reset during ISSUE
      push(128'h7777);
      push(128'h8888);
      wait_en("t6");
      rst_n = 1'b0;
      #1;
      chk1("t6_core_en", core_en, 1'b0);
      chk1("t6_in_ready", in_ready, 1'b1);
      chk1("t6_busy", busy, 1'b0);
      chk1("t6_out_valid", out_valid, 1'b0);
      chk1("t6_err", err_timeout, 1'b0);
      chk("t6_blk_count", 128'(blk_count), 128'd0);
      chk("t6_core_key", core_key, 128'd0);
      chk("t6_core_data_in", core_data_in, 128'd0);
      chk("t6_out_data", out_data, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      inj_valid = 1'b1;
      @(negedge clk);
      inj_valid = 1'b0;
      chk1("t6_stray_valid_out", out_valid, 1'b0);
      chk1("t6_stray_valid_busy", busy, 1'b0);
      chk("t6_stray_valid_count", 128'(blk_count), 128'd0);
      @(negedge clk);
      chk1("t6_still_no_out", out_valid, 1'b0);
      push(128'h9999);
      wait_en("t6b");
      wait_out("t6b");
      chk("t6_after_reset_block", out_data, enc(128'd0, 128'h9999));
      chk("t6_after_reset_count", 128'(blk_count), 128'd1);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
